// File: rtl/instr_fetch.sv
// instr_fetch: program counter, req/ack instruction fetch and field split
// for the single-cycle MIPS-subset core.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        core_ready,
   input  logic        nPC_sel,
   input  logic        zero,
   output logic        inst_valid,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [5:0]  funct,
   output logic [15:0] imm16
);
   typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;
   state_t      state_q;
   logic        req_q;
   logic        valid_q;
   logic [31:0] instr_q;
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   // branch offset is the sign-extended word offset, wrapping modulo 2^32
   assign pc_d = pc_q + 32'd4 + ((nPC_sel & zero) ? {{14{instr_q[15]}}, instr_q[15:0], 2'b00} : 32'd0);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         instr_q <= 32'd0;
         pc_q    <= RESET_PC;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= REQ;
               req_q   <= 1'b1;
            end
            REQ: if (imem_ack) begin
               state_q <= VALID;
               instr_q <= imem_rdata;
               req_q   <= 1'b0;
               valid_q <= 1'b1;
            end
            VALID: if (core_ready) begin
               state_q <= REQ;
               pc_q    <= pc_d;
               req_q   <= 1'b1;
               valid_q <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end
   assign imem_req   = req_q;
   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign inst_valid = valid_q;
   assign instr      = instr_q;
   assign opcode     = instr_q[31:26];
   assign rs         = instr_q[25:21];
   assign rt         = instr_q[20:16];
   assign rd         = instr_q[15:11];
   assign funct      = instr_q[5:0];
   assign imm16      = instr_q[15:0];
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and randomized checks of instr_fetch against a
// transaction-level model of fetch/commit and PC arithmetic.
module tb_instr_fetch;
   localparam int P_IDLE = 0, P_FETCH = 1, P_HOLD = 2;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_ack = 1'b0, core_ready = 1'b0, nPC_sel = 1'b0, zero = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        imem_req, inst_valid;
   logic [31:0] imem_addr, instr, pc;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm16;
   logic        w_ack = 1'b1, w_cr = 1'b1, w_nps = 1'b0, w_zero = 1'b0;
   logic [31:0] w_rdata = 32'h012A_4020;
   logic        w_req, w_valid;
   logic [31:0] w_addr, w_instr, w_pc;
   logic [5:0]  w_opcode, w_funct;
   logic [4:0]  w_rs, w_rt, w_rd;
   logic [15:0] w_imm16;
   int          n_chk = 0, n_fail = 0;
   int          ph = P_IDLE;
   logic [31:0] exp_pc = 32'd0, exp_instr = 32'd0;
   logic [31:0] mem [logic [31:0]];

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .core_ready(core_ready),
      .nPC_sel(nPC_sel), .zero(zero), .inst_valid(inst_valid), .instr(instr),
      .pc(pc), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm16(imm16)
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
      .imem_ack(w_ack), .imem_rdata(w_rdata), .core_ready(w_cr),
      .nPC_sel(w_nps), .zero(w_zero), .inst_valid(w_valid), .instr(w_instr),
      .pc(w_pc), .opcode(w_opcode), .rs(w_rs), .rt(w_rt), .rd(w_rd), .funct(w_funct), .imm16(w_imm16)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word(input logic [31:0] a);
      if (!mem.exists(a)) mem[a] = $urandom;
      return mem[a];
   endfunction

   task automatic check_all();
      check("req", {31'd0, imem_req}, {31'd0, ph == P_FETCH});
      check("valid", {31'd0, inst_valid}, {31'd0, ph == P_HOLD});
      check("addr", imem_addr, exp_pc);
      check("pc", pc, exp_pc);
      check("instr", instr, exp_instr);
      check("opcode", {26'd0, opcode}, {26'd0, exp_instr[31:26]});
      check("rs", {27'd0, rs}, {27'd0, exp_instr[25:21]});
      check("rt", {27'd0, rt}, {27'd0, exp_instr[20:16]});
      check("rd", {27'd0, rd}, {27'd0, exp_instr[15:11]});
      check("funct", {26'd0, funct}, {26'd0, exp_instr[5:0]});
      check("imm16", {16'd0, imm16}, {16'd0, exp_instr[15:0]});
   endtask

   // called at a falling edge: drive inputs, advance the model, check after the next rising edge
   task automatic tick(input logic a, input logic cr, input logic nps, input logic z);
      int off;
      imem_ack = a; core_ready = cr; nPC_sel = nps; zero = z;
      imem_rdata = (ph == P_FETCH) ? word(exp_pc) : $urandom;
      if (ph == P_IDLE) ph = P_FETCH;
      else if (ph == P_FETCH && a) begin
         exp_instr = word(exp_pc);
         ph = P_HOLD;
      end else if (ph == P_HOLD && cr) begin
         off = (nps && z) ? 4 * int'($signed(exp_instr[15:0])) : 0;
         exp_pc = exp_pc + 32'd4 + 32'(off);
         ph = P_FETCH;
      end
      @(negedge clk);
      check_all();
   endtask

   task automatic fetch_commit(input logic nps, input logic z);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, nps, z);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_pc", pc, 32'd0);
      check("rst_addr", imem_addr, 32'd0);
      check("rst_instr", instr, 32'd0);
      ph = P_IDLE; exp_pc = 32'd0; exp_instr = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      mem[32'h0]  = 32'h012A_4020;
      mem[32'h4]  = 32'h014B_4822;
      mem[32'h8]  = 32'h016C_5020;
      mem[32'hC]  = 32'h0000_0000;
      mem[32'h10] = 32'h1000_0003;
      @(negedge clk);
      do_reset();
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("first_req", {31'd0, imem_req}, 32'd1);
      check("first_addr", imem_addr, 32'd0);
      check("wrap_req", {31'd0, w_req}, 32'd1);
      check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("first_instr", instr, 32'h012A_4020);
      check("f_opcode", {26'd0, opcode}, 32'd0);
      check("f_rs", {27'd0, rs}, 32'd9);
      check("f_rt", {27'd0, rt}, 32'd10);
      check("f_rd", {27'd0, rd}, 32'd8);
      check("f_funct", {26'd0, funct}, 32'h20);
      check("wrap_valid", {31'd0, w_valid}, 32'd1);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      check("seq_pc4", imem_addr, 32'h4);
      check("wrap_addr1", w_addr, 32'h0000_0000);
      check("wrap_req1", {31'd0, w_req}, 32'd1);
      fetch_commit(1'b0, 1'b0);
      check("seq_pc8", imem_addr, 32'h8);
      fetch_commit(1'b0, 1'b0);
      fetch_commit(1'b0, 1'b0);
      fetch_commit(1'b1, 1'b1);
      check("beq_taken", imem_addr, 32'h20);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (5) tick(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b1);
      check("stall_pc", pc, 32'h20);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("wait_addr", imem_addr, 32'h24);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      do_reset();
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) fetch_commit(1'b0, 1'b0);
      fetch_commit(1'b1, 1'b0);
      check("beq_not_taken", imem_addr, 32'h14);
      mem[32'h10] = 32'h1000_FFFC;
      do_reset();
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) fetch_commit(1'b0, 1'b0);
      fetch_commit(1'b1, 1'b1);
      check("beq_backward", imem_addr, 32'h04);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      do_reset();
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("restart_addr", imem_addr, 32'h0);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
            tick(1'b0, 1'b0, 1'b0, 1'b0);
         end else begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
